// File: rtl/centroid_tracker_if.sv
// Video and result bundle for centroid_tracker.
// slave = tracker side, master = source/sink side.
interface centroid_tracker_if #(
   parameter int CNT_W = 11
) ();
   logic             de_in;
   logic             h_sync_in;
   logic             v_sync_in;
   logic [23:0]      pixel_in;
   logic             de_out;
   logic             h_sync_out;
   logic             v_sync_out;
   logic [23:0]      pixel_out;
   logic [CNT_W-1:0] x_out;
   logic [CNT_W-1:0] y_out;
   logic             found_out;
   logic             centroid_valid;
   logic             overrun;

   modport slave (
      input  de_in, h_sync_in, v_sync_in, pixel_in,
      output de_out, h_sync_out, v_sync_out, pixel_out,
      output x_out, y_out, found_out, centroid_valid, overrun
   );

   modport master (
      output de_in, h_sync_in, v_sync_in, pixel_in,
      input  de_out, h_sync_out, v_sync_out, pixel_out,
      input  x_out, y_out, found_out, centroid_valid, overrun
   );
endinterface

// File: rtl/centroid_tracker.sv
// Mask centroid tracker: per-frame moments, serial divide in blanking.
// Ports: clk, rst (async high), bus (video in/out + centroid results).
module centroid_tracker #(
   parameter int CNT_W = 11,
   parameter int ACC_W = 32
) (
   input  logic clk,
   input  logic rst,
   centroid_tracker_if.slave bus
);
   localparam int SW = $clog2(ACC_W + 1);

   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_e;

   state_e state_q, state_d;

   logic             vs_q, de_q;
   logic [CNT_W-1:0] x_cnt_q, y_cnt_q;
   logic [ACC_W-1:0] m00_q, m10_q, m01_q;
   logic [ACC_W-1:0] den_q, num_y_q, quo_q, rem_q;
   logic [CNT_W-1:0] qx_q;
   logic [SW-1:0]    step_q;

   logic             rise, hit, last;
   logic [ACC_W-1:0] m00_f, m10_f, m01_f;
   logic [ACC_W:0]   rem_sh, diff;
   logic             q_bit;
   logic [ACC_W-1:0] quo_nx, rem_nx;

   assign rise = bus.v_sync_in & ~vs_q;
   assign hit  = bus.de_in & bus.pixel_in[7];

   // Sums including this cycle's pixel, so a frame end sees it.
   assign m00_f = m00_q + ACC_W'(hit);
   assign m10_f = m10_q + (hit ? ACC_W'(x_cnt_q) : '0);
   assign m01_f = m01_q + (hit ? ACC_W'(y_cnt_q) : '0);

   // Restoring divide step: borrow out of diff means "does not fit".
   assign rem_sh = {rem_q, quo_q[ACC_W-1]};
   assign diff   = rem_sh - {1'b0, den_q};
   assign q_bit  = ~diff[ACC_W];
   assign rem_nx = q_bit ? diff[ACC_W-1:0] : rem_sh[ACC_W-1:0];
   assign quo_nx = {quo_q[ACC_W-2:0], q_bit};
   assign last   = (step_q == SW'(ACC_W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (rise) state_d = (m00_f == '0) ? DONE : DIV_X;
         DIV_X: if (last) state_d = DIV_Y;
         DIV_Y: if (last) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_q               <= 1'b0;
         de_q               <= 1'b0;
         bus.de_out         <= 1'b0;
         bus.h_sync_out     <= 1'b0;
         bus.v_sync_out     <= 1'b0;
         bus.pixel_out      <= '0;
         x_cnt_q            <= '0;
         y_cnt_q            <= '0;
         m00_q              <= '0;
         m10_q              <= '0;
         m01_q              <= '0;
         den_q              <= '0;
         num_y_q            <= '0;
         quo_q              <= '0;
         rem_q              <= '0;
         qx_q               <= '0;
         step_q             <= '0;
         bus.x_out          <= '0;
         bus.y_out          <= '0;
         bus.found_out      <= 1'b0;
         bus.centroid_valid <= 1'b0;
         bus.overrun        <= 1'b0;
      end else begin
         vs_q           <= bus.v_sync_in;
         de_q           <= bus.de_in;
         bus.de_out     <= bus.de_in;
         bus.h_sync_out <= bus.h_sync_in;
         bus.v_sync_out <= bus.v_sync_in;
         bus.pixel_out  <= bus.pixel_in;

         if (bus.de_in)   x_cnt_q <= x_cnt_q + 1'b1;
         else if (de_q)   x_cnt_q <= '0;

         if (rise)                     y_cnt_q <= '0;
         else if (de_q & ~bus.de_in)   y_cnt_q <= y_cnt_q + 1'b1;

         if (rise) begin
            m00_q <= '0;
            m10_q <= '0;
            m01_q <= '0;
         end else begin
            m00_q <= m00_f;
            m10_q <= m10_f;
            m01_q <= m01_f;
         end

         // Frame end mid-division: sums dropped, division carries on.
         if (rise && state_q != IDLE) bus.overrun <= 1'b1;

         bus.centroid_valid <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (rise) begin
                  den_q   <= m00_f;
                  quo_q   <= m10_f;
                  num_y_q <= m01_f;
                  rem_q   <= '0;
                  step_q  <= '0;
               end
            end
            DIV_X: begin
               step_q <= last ? '0 : step_q + 1'b1;
               if (last) begin
                  qx_q  <= quo_nx[CNT_W-1:0];
                  quo_q <= num_y_q;
                  rem_q <= '0;
               end else begin
                  quo_q <= quo_nx;
                  rem_q <= rem_nx;
               end
            end
            DIV_Y: begin
               step_q <= last ? '0 : step_q + 1'b1;
               quo_q  <= quo_nx;
               rem_q  <= rem_nx;
            end
            DONE: begin
               bus.centroid_valid <= 1'b1;
               bus.found_out      <= (den_q != '0);
               if (den_q != '0) begin
                  bus.x_out <= qx_q;
                  bus.y_out <= quo_q[CNT_W-1:0];
               end
            end
            default: ;
         endcase
      end
   end
endmodule
